ram_array_2r1w: RTL and testbench
=================================

# ram_array_2r1w

Parametrised synchronous RAM for the toy processor's data and register storage: one write port, two independent registered read ports. Each read port feeds one processor operand. After every reset, a built-in sweep loads `INIT_VALUE` into every location, so the processor never sees undefined memory. Replaces the fixed 8-bit × 256, single-read-port RAM array.

## Interface
Parameters:
- `DW`, 8, data width in bits
- `AW`, 8, address width in bits
- `DEPTH`, 256, number of words; must satisfy 1 ≤ `DEPTH` ≤ 2^`AW`
- `INIT_VALUE`, 0, `DW`-bit value written to every word during the post-reset sweep

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge
- `RST_N`  in  1  reset; asynchronous, active-low
- `WE`  in  1  write enable
- `WADDR`  in  `AW`  write address
- `DATA_IN`  in  `DW`  write data
- `RADDR1`  in  `AW`  read address, port 1
- `RADDR2`  in  `AW`  read address, port 2
- `DATA_OUT1`  out  `DW`  registered read data, port 1
- `DATA_OUT2`  out  `DW`  registered read data, port 2
- `BUSY`  out  1  high while the init sweep runs; user writes and reads are not serviced

## Operation
- The controller has two states, INIT and READY.
- **While `RST_N`=0:**
  - State is forced to INIT and the sweep counter to 0.
  - `BUSY`=1, `DATA_OUT1`=0, `DATA_OUT2`=0.
  - Memory contents are not touched.
- **INIT state (after `RST_N` deasserts):**
  - Each rising edge writes `INIT_VALUE` to `mem[counter]`, then increments the counter.
  - The edge that writes address `DEPTH`-1 moves the state to READY and clears `BUSY`.
  - `WE` is ignored for the whole of INIT.
  - `DATA_OUT1` and `DATA_OUT2` hold 0.
- **READY state, writes:** if `WE`=1 and `WADDR` < `DEPTH`, `mem[WADDR]` ← `DATA_IN`.
- **READY state, reads:** each port registers `mem[RADDRn]` every cycle. There is no read enable.
- **Out-of-range addresses** (address ≥ `DEPTH`): the write is dropped and the read port registers 0.
- **Both ports on the same address:** both return the same word. The ports never interact.
- **Reset asserted mid-sweep or during READY:** takes effect immediately (asynchronous). The sweep restarts from address 0 after release, and all prior contents are overwritten.
- **Counter width:** the sweep counter is `AW`+1 bits wide, so `DEPTH` = 2^`AW` terminates without wrap-around.

## Timing
- **Read latency:** 1 cycle. The address presented before edge N appears on `DATA_OUTn` after edge N.
- **Write:** takes effect at the edge where `WE` is sampled high. A read of the same address at the next edge returns the new data.
- **Sweep duration:** exactly `DEPTH` rising edges after `RST_N` deassertion. `BUSY` falls after edge `DEPTH`.
- **First usable cycle:** the first user write or read is sampled on edge `DEPTH`+1.
- **Read-during-write** (same edge, `WE`=1, `WADDR`==`RADDRn`): the result depends on the macro in Configuration.

## Configuration
- **Macro:** `RAM_ARRAY_BYPASS_EN`.
- **Defined:** a read-during-write to the same address forwards `DATA_IN` to `DATA_OUTn`. This gives write-first behaviour, independently per port.
- **Undefined:** the read returns the word stored before the write (read-first). The new value is visible from the following read.
- **Either setting:** the memory contents after the edge are identical.

## Structure
- **Package `ram_pkg`:**
  - Default `DW`/`AW`/`DEPTH` constants.
  - Controller state typedef (INIT, READY).
- **Sub-module `ram_init_ctrl`:**
  - Holds the state machine and sweep counter.
  - Outputs `BUSY`, the sweep address and the sweep write strobe.
- **Top level:**
  - Muxes the sweep address/data against the user write port.
  - Holds the memory array and both read registers.

## Test plan
All scenarios use `DW`=8, `AW`=8, `DEPTH`=256, `INIT_VALUE`=0, 100 ns clock.
1. **Reset and sweep:** release `RST_N` → `BUSY` stays high for exactly 256 edges, then 0. Reading every address returns 0x00 with `DATA_OUT1`/`DATA_OUT2` = 0 throughout INIT.
2. **Dual-port readback:** write `mem[i]`=i for i=1..255, then set `RADDR1`=i and `RADDR2`=255-i → one cycle later `DATA_OUT1`=i and `DATA_OUT2`=255-i for all i.
3. **Writes ignored during INIT:** during INIT drive `WE`=1, `WADDR`=5, `DATA_IN`=0xAF → after READY, a read of address 5 returns 0x00.
4. **Read-during-write:** with `mem[0x10]`=0x11, write 0xAF to 0x10 while `RADDR1`=0x10 → next cycle `DATA_OUT1`=0xAF if `RAM_ARRAY_BYPASS_EN` is defined, 0x11 if not. The following cycle returns 0xAF in both builds.
5. **Reset mid-sweep:** write 0x55 to address 200, then pulse `RST_N` low mid-cycle at sweep count 100 → outputs go 0 asynchronously and `BUSY` stays 1. After release, `BUSY` lasts another full 256 edges and address 200 reads 0x00.
6. **Out-of-range address:** rebuild with `DEPTH`=200, write 0x3C to address 210 → read 210 returns 0x00 and address 199 is unchanged. Sweep length is 200 edges.

Source files
------------

// File: rtl/ram_pkg.sv
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared defaults and controller state type for ram_array_2r1w.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/ram_init_ctrl.sv
// ============================================================================
// Module   : ram_init_ctrl
// Brief    : Post-reset sweep controller; walks every address once, then idles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic [AW-1:0] sweep_addr,
  output logic          sweep_we
);

  // One extra bit lets DEPTH == 2**AW finish without wrapping back to 0.
  localparam logic [AW:0] c_last = (AW+1)'(DEPTH - 1);

  ctrl_state_e   state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        busy = 1'b0;
      end
    endcase
  end

  assign sweep_addr = cnt_q[AW-1:0];

endmodule

`default_nettype wire

// File: rtl/ram_array_2r1w.sv
// ============================================================================
// Module   : ram_array_2r1w
// Brief    : 1-write / 2-read synchronous RAM with self-initialising sweep.
//            Define RAM_ARRAY_BYPASS_EN for write-first read-during-write.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_array_2r1w
  import ram_pkg::*;
#(
  parameter int            DW         = DW_DEF,
  parameter int            AW         = AW_DEF,
  parameter int            DEPTH      = DEPTH_DEF,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WE,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] DATA_IN,
  input  logic [AW-1:0] RADDR1,
  input  logic [AW-1:0] RADDR2,
  output logic [DW-1:0] DATA_OUT1,
  output logic [DW-1:0] DATA_OUT2,
  output logic          BUSY
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd1_q, rd1_d;
  logic [DW-1:0] rd2_q, rd2_d;

  logic          w_busy;
  logic [AW-1:0] w_sweep_addr;
  logic          w_sweep_we;
  logic          w_user_we;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic          w_rd1_ok;
  logic          w_rd2_ok;

  ram_init_ctrl #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (CLK),
    .rst_n      (RST_N),
    .busy       (w_busy),
    .sweep_addr (w_sweep_addr),
    .sweep_we   (w_sweep_we)
  );

  // The sweep owns the write port until it finishes; user writes are dropped.
  always_comb begin
    w_user_we = !w_busy && WE && ({1'b0, WADDR} < c_depth);
    w_rd1_ok  = ({1'b0, RADDR1} < c_depth);
    w_rd2_ok  = ({1'b0, RADDR2} < c_depth);
    w_wr_en   = w_busy ? w_sweep_we   : w_user_we;
    w_wr_addr = w_busy ? w_sweep_addr : WADDR;
    w_wr_data = w_busy ? INIT_VALUE   : DATA_IN;
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      mem_q[w_wr_addr] <= w_wr_data;
    end
  end

  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (!w_busy && w_rd1_ok) begin
      rd1_d = mem_q[RADDR1];
`ifdef RAM_ARRAY_BYPASS_EN
      if (w_user_we && (WADDR == RADDR1)) begin
        rd1_d = DATA_IN;
      end
`endif
    end
    if (!w_busy && w_rd2_ok) begin
      rd2_d = mem_q[RADDR2];
`ifdef RAM_ARRAY_BYPASS_EN
      if (w_user_we && (WADDR == RADDR2)) begin
        rd2_d = DATA_IN;
      end
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign DATA_OUT1 = rd1_q;
  assign DATA_OUT2 = rd2_q;
  assign BUSY      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_ram_array_2r1w.sv
// ============================================================================
// Module   : tb_ram_array_2r1w
// Brief    : Scoreboard bench driving a DEPTH=256 and a DEPTH=200 instance in
//            parallel against an array-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_array_2r1w;

`ifdef RAM_ARRAY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int DEP0 = 256;
  localparam int DEP1 = 200;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       we    = 1'b0;
  logic [7:0] waddr = '0;
  logic [7:0] din   = '0;
  logic [7:0] ra1   = '0;
  logic [7:0] ra2   = '0;

  logic [7:0] q1_a, q2_a, q1_b, q2_b;
  logic       busy_a, busy_b;

  always #50 clk = ~clk;

  ram_array_2r1w #(.DW(8), .AW(8), .DEPTH(DEP0), .INIT_VALUE(8'h00)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .DATA_IN(din),
    .RADDR1(ra1), .RADDR2(ra2), .DATA_OUT1(q1_a), .DATA_OUT2(q2_a), .BUSY(busy_a)
  );

  ram_array_2r1w #(.DW(8), .AW(8), .DEPTH(DEP1), .INIT_VALUE(8'h00)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .DATA_IN(din),
    .RADDR1(ra1), .RADDR2(ra2), .DATA_OUT1(q1_b), .DATA_OUT2(q2_b), .BUSY(busy_b)
  );

  typedef struct packed {
    logic [1:0][7:0] d1;
    logic [1:0][7:0] d2;
    logic [1:0]      busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] mem_m [2][256];
  int         sweep_m [2];
  int         dep_m [2] = '{DEP0, DEP1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input int k, input logic w, input logic [7:0] wa,
                                          input logic [7:0] d, input logic [7:0] ra);
    if (int'(ra) >= dep_m[k]) return 8'h00;
    if (BYP && w && (wa == ra)) return d;
    return mem_m[k][ra];
  endfunction

  // Apply one cycle of inputs and queue what both instances must show after the edge.
  task automatic issue(input logic w, input logic [7:0] wa, input logic [7:0] d,
                       input logic [7:0] r1, input logic [7:0] r2);
    exp_t e;
    @(negedge clk);
    we = w; waddr = wa; din = d; ra1 = r1; ra2 = r2;
    for (int k = 0; k < 2; k++) begin
      if (sweep_m[k] < dep_m[k]) begin
        mem_m[k][sweep_m[k]] = 8'h00;
        sweep_m[k]++;
        e.d1[k]   = 8'h00;
        e.d2[k]   = 8'h00;
        e.busy[k] = (sweep_m[k] < dep_m[k]);
      end else begin
        e.d1[k]   = model_rd(k, w, wa, d, r1);
        e.d2[k]   = model_rd(k, w, wa, d, r2);
        e.busy[k] = 1'b0;
        if (w && (int'(wa) < dep_m[k])) mem_m[k][wa] = d;
      end
    end
    sb_q.push_back(e);
  endtask

  // Mid-cycle reset pulse spanning exactly one rising edge.
  task automatic reset_pulse();
    @(posedge clk);
    #20;
    rst_n = 1'b0;
    #1;
    chk("rst_dout1_a", q1_a, 8'h00);
    chk("rst_dout2_a", q2_a, 8'h00);
    chk("rst_busy_a", busy_a, 1'b1);
    chk("rst_dout1_b", q1_b, 8'h00);
    chk("rst_dout2_b", q2_b, 8'h00);
    chk("rst_busy_b", busy_b, 1'b1);
    sweep_m[0] = 0;
    sweep_m[1] = 0;
    #100;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("dout1_a", q1_a, e.d1[0]);
        chk("dout2_a", q2_a, e.d2[0]);
        chk("busy_a", busy_a, e.busy[0]);
        chk("dout1_b", q1_b, e.d1[1]);
        chk("dout2_b", q2_b, e.d2[1]);
        chk("busy_b", busy_b, e.busy[1]);
      end
    end
  end

  initial begin : driver
    logic [7:0] a, b;
    sweep_m[0] = 0;
    sweep_m[1] = 0;

    reset_pulse();
    // Writes attempted during the sweep, including 0xAF to address 5.
    for (int i = 0; i < 256; i++) begin
      if (i == 10) issue(1'b1, 8'd5, 8'hAF, 8'($urandom), 8'($urandom));
      else         issue(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 256; i++) issue(1'b0, 8'h00, 8'h00, 8'(i), 8'(255 - i));

    for (int i = 1; i < 256; i++) issue(1'b1, 8'(i), 8'(i), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 256; i++) issue(1'b0, 8'h00, 8'h00, 8'(i), 8'(255 - i));

    issue(1'b1, 8'h10, 8'h11, 8'h00, 8'h00);
    issue(1'b1, 8'h10, 8'hAF, 8'h10, 8'h10);
    issue(1'b0, 8'h00, 8'h00, 8'h10, 8'h10);

    issue(1'b1, 8'd210, 8'h3C, 8'h00, 8'h00);
    issue(1'b0, 8'h00, 8'h00, 8'd210, 8'd199);

    for (int i = 0; i < 2000; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 8'(8'h0E + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 255));
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), b, 8'($urandom_range(0, 255)));
    end

    issue(1'b1, 8'd200, 8'h55, 8'h00, 8'h00);
    issue(1'b0, 8'h00, 8'h00, 8'd200, 8'd200);
    reset_pulse();
    for (int i = 0; i < 100; i++) issue(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    reset_pulse();
    for (int i = 0; i < 256; i++) issue(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    issue(1'b0, 8'h00, 8'h00, 8'd200, 8'd199);
    issue(1'b0, 8'h00, 8'h00, 8'd5, 8'h10);

    @(posedge clk);
    #5;
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
